// File: rtl/arith_issue.sv
// arith_issue -- sequences one arithmetic operation at a time through an
// external register file and an external arithmetic unit.
//
// Each accepted op walks IDLE -> RD1 -> RD2 -> EXEC -> WB -> IDLE. The walk
// takes one cycle per non-IDLE state, so the block accepts one op every five
// cycles.
//
// Ports
//   clk, rst_n            clock; asynchronous active-low reset
//   issue_valid/ready     op handshake (see below)
//   issue_ctrl[2:0]       010 add, 011 sub, 100 asl, 101 asr, 110 uadd,
//                         111 usub, 000/001 reserved (no write, no flags)
//   issue_hex[3:0]        shift amount for asl/asr
//   issue_rs1/rs2/rd      source and destination register numbers
//   rf_raddr / rf_rdata   combinational register-file read port
//   rf_we/waddr/wdata     register-file write port (one pulse, in WB)
//   alu_*                 drive of the arithmetic unit (non-zero only in EXEC)
//   alu_value_out/flags   result and flags returned by the arithmetic unit
//   flags_q               architectural flags
//   busy                  high whenever an op is in flight (== !issue_ready)
//   dbg_state             current FSM state, for observation only
//
// Handshake: an op transfers on a rising clk edge where issue_valid and
// issue_ready are both high. issue_ready is high only in IDLE. The issue_*
// fields are sampled on that edge only and are ignored at all other times.
//
// Build option: define ARITH_ISSUE_ZERO_REG_EN to make register 0 read as
// zero and to suppress writes whose destination is register 0. Flags still
// update for such writes. Without the macro, register 0 is an ordinary
// register.

module arith_issue #(
  parameter int RA_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [2:0]      issue_ctrl,
  input  logic [3:0]      issue_hex,
  input  logic [RA_W-1:0] issue_rs1,
  input  logic [RA_W-1:0] issue_rs2,
  input  logic [RA_W-1:0] issue_rd,
  output logic [RA_W-1:0] rf_raddr,
  input  logic [31:0]     rf_rdata,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic [31:0]     alu_value1,
  output logic [31:0]     alu_value2,
  output logic [2:0]      alu_control,
  output logic [3:0]      alu_shift_hex,
  output logic            alu_en,
  input  logic [31:0]     alu_value_out,
  input  logic [1:0]      alu_flags,
  output logic [1:0]      flags_q,
  output logic            busy,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [3:0]      hex_q, hex_d;
  logic [RA_W-1:0] rs1_q, rs1_d;
  logic [RA_W-1:0] rs2_q, rs2_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [31:0]     op1_q, op1_d;
  logic [31:0]     op2_q, op2_d;
  logic [31:0]     res_q, res_d;
  logic [1:0]      fcap_q, fcap_d;
  logic [1:0]      flags_d;

  logic [31:0]     rdata_eff;
  logic            wr_ok;
  logic            flag_upd;

  // ctrl bit 1 is set exactly for add/sub/uadd/usub: the ops that own flags.
  assign flag_upd = ctrl_q[1];

  // Reserved encodings (000/001) are the only ones with both upper bits low.
`ifdef ARITH_ISSUE_ZERO_REG_EN
  assign wr_ok     = (ctrl_q[2] | ctrl_q[1]) && (rd_q != '0);
  assign rdata_eff = (rf_raddr == '0) ? 32'h0 : rf_rdata;
`else
  assign wr_ok     = ctrl_q[2] | ctrl_q[1];
  assign rdata_eff = rf_rdata;
`endif

  assign dbg_state = state_q;

  // Output decode. Every output is a function of the current state and the
  // latched fields only, so the reset values follow from state_q == S_IDLE.
  always_comb begin
    issue_ready   = 1'b0;
    rf_raddr      = '0;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = 32'h0;
    alu_en        = 1'b0;
    alu_value1    = 32'h0;
    alu_value2    = 32'h0;
    alu_control   = 3'b000;
    alu_shift_hex = 4'h0;
    case (state_q)
      S_IDLE: issue_ready = 1'b1;
      S_RD1:  rf_raddr = rs1_q;
      S_RD2:  rf_raddr = rs2_q;
      S_EXEC: begin
        alu_en        = 1'b1;
        alu_value1    = op1_q;
        alu_value2    = op2_q;
        alu_control   = ctrl_q;
        alu_shift_hex = hex_q;
      end
      S_WB: begin
        if (wr_ok) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = res_q;
        end
      end
      default: ;
    endcase
    busy = ~issue_ready;
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    hex_d   = hex_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    fcap_d  = fcap_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (issue_valid) begin
          ctrl_d  = issue_ctrl;
          hex_d   = issue_hex;
          rs1_d   = issue_rs1;
          rs2_d   = issue_rs2;
          rd_d    = issue_rd;
          state_d = S_RD1;
        end
      end
      S_RD1: begin
        op1_d   = rdata_eff;
        state_d = S_RD2;
      end
      S_RD2: begin
        op2_d   = rdata_eff;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_value_out;
        fcap_d  = alu_flags;
        state_d = S_WB;
      end
      S_WB: begin
        // Flags follow the op type, not whether the write was suppressed.
        if (flag_upd) flags_d = fcap_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= 3'b000;
      hex_q   <= 4'h0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      op1_q   <= 32'h0;
      op2_q   <= 32'h0;
      res_q   <= 32'h0;
      fcap_q  <= 2'b00;
      flags_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      hex_q   <= hex_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      fcap_q  <= fcap_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: doc/arith_issue.md
ARITH_ISSUE -- requirements
Module: arith_issue

Interface
REQ-001 SHALL provide parameter RA_W, default 4, width of register-file addresses and issue register fields.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide issue_valid input 1 and issue_ready output 1: op handshake, transfer when both high on a clk edge.
REQ-005 SHALL provide issue_ctrl input 3 (arith encoding: 010 add, 011 sub, 100 asl, 101 asr, 110 uadd, 111 usub, 000/001 reserved), issue_hex input 4 (shift amount nibble).
REQ-006 SHALL provide issue_rs1, issue_rs2, issue_rd, each input RA_W: source and destination registers.
REQ-007 SHALL provide rf_raddr output RA_W and rf_rdata input 32: single combinational register-file read port.
REQ-008 SHALL provide rf_we output 1, rf_waddr output RA_W, rf_wdata output 32: register-file write port.
REQ-009 SHALL provide alu_value1, alu_value2 outputs 32, alu_control output 3, alu_shift_hex output 4, alu_en output 1: drive of the arithmetic unit.
REQ-010 SHALL provide alu_value_out input 32 and alu_flags input 2: arithmetic unit result and flags.
REQ-011 SHALL provide flags_q output 2 (architectural flags) and busy output 1.

Function
REQ-012 SHALL implement FSM IDLE -> RD1 -> RD2 -> EXEC -> WB -> IDLE, one cycle per non-IDLE state.
REQ-013 SHALL assert issue_ready only in IDLE; busy SHALL equal NOT issue_ready.
REQ-014 On handshake SHALL latch ctrl, hex, rs1, rs2, rd and enter RD1; issue_* ignored outside IDLE.
REQ-015 RD1: rf_raddr = latched rs1, capture rf_rdata as op1; RD2: rf_raddr = latched rs2, capture op2; rf_raddr = 0 in IDLE, EXEC, WB.
REQ-016 EXEC: alu_en = 1, alu_value1 = op1, alu_value2 = op2, alu_control/alu_shift_hex = latched values; capture alu_value_out and alu_flags at end of EXEC.
REQ-017 alu_en SHALL be 0 and alu_value1/alu_value2/alu_control/alu_shift_hex SHALL be 0 outside EXEC.
REQ-018 WB: rf_we = 1 for exactly one cycle with rf_waddr = latched rd, rf_wdata = captured result; rf_we = 0 in all other states, rf_waddr/rf_wdata = 0 when rf_we = 0.
REQ-019 flags_q SHALL update from captured alu_flags in WB only for ctrl 010, 011, 110, 111; asl/asr SHALL leave flags_q unchanged.
REQ-020 Reserved ctrl 000/001 SHALL still traverse all states but SHALL NOT assert rf_we nor update flags_q.
REQ-021 Latency: handshake at edge N -> rf_we high in cycle N+4 -> issue_ready high again in cycle N+5; throughput one op per 5 cycles.
REQ-022 rs1 = rs2 = rd SHALL be legal; reads SHALL return pre-write values (write occurs after both reads).

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, flags_q = 0, all latched fields/operands/result = 0, all outputs 0 except issue_ready = 1.
REQ-024 Reset during any non-IDLE state SHALL abort the op with no rf_we pulse; first post-reset cycle SHALL be IDLE.

Configuration
REQ-025 With ARITH_ISSUE_ZERO_REG_EN defined, register 0 SHALL read as 32'h0 regardless of rf_rdata and writes with rd = 0 SHALL suppress rf_we (flags still update per REQ-019).
REQ-026 Without ARITH_ISSUE_ZERO_REG_EN, register 0 SHALL be an ordinary register.

Verification
REQ-027 Reset then add: ctrl=010, rs1=1 (5), rs2=2 (7), rd=3 -> rf_we one cycle at N+4, waddr=3, wdata=12, flags_q=alu_flags.
REQ-028 asl after a sub setting flags_q=2'b10: ctrl=100, hex=4, r1=1 -> wdata=16, flags_q stays 2'b10.
REQ-029 Back-to-back valid held high with two ops -> second handshake exactly 5 cycles after first, no overlap of rf_we.
REQ-030 rst_n low in EXEC -> no rf_we, issue_ready=1 immediately, flags_q=0.
REQ-031 ctrl=000, rd=4 -> full 5-cycle traversal, rf_we never high, flags_q unchanged.
REQ-032 With ARITH_ISSUE_ZERO_REG_EN: rs1=0 with rf_rdata=32'hFFFF_FFFF, add r2=3, rd=0 -> alu_value1=0, rf_we stays 0.
